// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port SRAM macro (RW port 0).
// Responses return on a fixed two-cycle tag pipeline, in transfer order.
module sram_port_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,

  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic                  r0_we,
  input  logic [NUM_WMASKS-1:0] r0_wmask,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_rsp_valid,
  output logic [DATA_WIDTH-1:0] r0_rsp_rdata,

  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic                  r1_we,
  input  logic [NUM_WMASKS-1:0] r1_wmask,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_rsp_valid,
  output logic [DATA_WIDTH-1:0] r1_rsp_rdata,

  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  logic                  last_grant;
  logic                  pref_r1;
  logic                  xfer;
  logic                  xfer_id;
  logic                  xfer_we;
  logic                  s1_valid;
  logic                  s1_id;
  logic                  s1_we;
  logic                  s2_valid;
  logic                  s2_id;
  logic [DATA_WIDTH-1:0] r0_rdata_q;
  logic [DATA_WIDTH-1:0] r1_rdata_q;

  // Handshake: a transfer happens in any cycle where rN_valid and rN_ready are both high;
  // ready is a pure function of this cycle's valids and last_grant, never of a response.
  assign pref_r1 = ~last_grant;

  always_comb begin
    r0_ready = r0_valid & ~wb_rst_i & (~r1_valid | ~pref_r1);
    r1_ready = r1_valid & ~wb_rst_i & (~r0_valid | pref_r1);
  end

  assign xfer    = r0_ready | r1_ready;
  assign xfer_id = r1_ready;
  assign xfer_we = r1_ready ? r1_we : r0_we;

  always_comb begin
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = '0;
    sram_addr0  = '0;
    sram_din0   = '0;
    if (r0_ready) begin
      sram_csb0   = 1'b0;
      sram_web0   = ~r0_we;
      sram_wmask0 = r0_we ? r0_wmask : '0;
      sram_addr0  = r0_addr;
      sram_din0   = r0_wdata;
    end else if (r1_ready) begin
      sram_csb0   = 1'b0;
      sram_web0   = ~r1_we;
      sram_wmask0 = r1_we ? r1_wmask : '0;
      sram_addr0  = r1_addr;
      sram_din0   = r1_wdata;
    end
  end

  // The macro drives dout0 at the negedge inside stage 1, so stage 1 ends with the capture.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      last_grant <= 1'b1;
      s1_valid   <= 1'b0;
      s1_id      <= 1'b0;
      s1_we      <= 1'b0;
      s2_valid   <= 1'b0;
      s2_id      <= 1'b0;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
    end else begin
      if (xfer) last_grant <= xfer_id;
      s1_valid <= xfer;
      s1_id    <= xfer_id;
      s1_we    <= xfer_we;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      if (s1_valid && !s1_we) begin
        if (s1_id) r1_rdata_q <= sram_dout0;
        else       r0_rdata_q <= sram_dout0;
      end
    end
  end

  assign r0_rsp_valid = s2_valid & ~s2_id;
  assign r1_rsp_valid = s2_valid &  s2_id;
  assign r0_rsp_rdata = r0_rdata_q;
  assign r1_rsp_rdata = r1_rdata_q;

endmodule
